alien_bomb: RTL and testbench
=============================

Name: alien_bomb

Overview:
- Downward counterpart of the player missile logic. Alien shots fall toward the player.
- Manages a fixed pool of bomb slots. Each slot is launched from the alien column chosen by the invader controller and moves down on a divided motion tick.
- Detects when a bomb overlaps the player sprite and reports it as a one-cycle hit pulse.
- Drives a per-pixel bomb mask and colour nibble into the VGA pixel mux, alongside the player and missile outputs.

Parameters:
- NUM_BOMBS, 4: number of bomb slots.
- MOVE_DIV, 250000: clk cycles per motion tick.
- STEP, 2: rows a bomb descends per tick.
- FIRE_INTERVAL, 32: motion ticks between fire attempts.
- BOTTOM_ROW, 470: a bomb whose row is >= this value is retired.
- PLAYER_ROW, 440: fixed top row reference of the player sprite.

Ports:
- clk  in  1  pixel clock.
- rst  in  1  synchronous, active-high reset.
- pixel_row  in  12  current VGA row.
- pixel_column  in  12  current VGA column.
- fire_col  in  12  column reference of the shooting alien (same 31-wide convention as the player).
- fire_row  in  12  launch row of the shooting alien's bomb.
- fire_valid  in  1  a shooter exists (at least one alien alive).
- player_column  in  12  player column reference (same signal that drives the player sprite).
- game_en  in  1  1 = running, 0 = frozen.
- bomb_active  out  1  current pixel lies inside a live bomb.
- bomb_output  out  4  4'b1111 when bomb_active, else 4'b0000.
- player_hit  out  1  one-cycle pulse when a bomb strikes the player.
- bombs_live  out  NUM_BOMBS  slot occupancy flags.

Behaviour:
- Reset (rst=1 at posedge clk):
  - all slots free; slot row/col = 0.
  - motion counter = 0; fire counter = 0.
  - player_hit = 0; bombs_live = 0.
  - bomb_active/bomb_output = 0, because they are derived only from live slots.
  - Reset mid-flight discards all bombs immediately.
- Motion counter:
  - counts 0..MOVE_DIV-1 while game_en=1.
  - tick = 1 for the single cycle where counter == MOVE_DIV-1; counter then wraps to 0.
  - game_en=0 holds the counter, all slots and the fire counter; rendering continues.
- Bomb geometry for a slot with row r, col c:
  - rows r+1..r+4, columns c+15..c+16 (2x4 pixels).
  - Player rectangle: rows PLAYER_ROW+1..PLAYER_ROW+20, columns player_column+1..player_column+30.
- On tick, for each live slot:
  - new row rn = r + STEP, computed in 12 bits.
  - if the bomb at rn overlaps the player rectangle: free the slot and flag a hit.
  - else if rn >= BOTTOM_ROW: free the slot.
  - else: row <= rn; col unchanged.
- player_hit:
  - asserted for exactly the one cycle after a tick with >= 1 hit.
  - multiple simultaneous hits produce a single pulse.
  - never asserted except on the cycle after a tick.
- Fire counter:
  - increments on each tick.
  - on the tick where it equals FIRE_INTERVAL-1 it resets to 0 and a fire attempt occurs.
- Fire attempt:
  - if fire_valid=1 and any slot was free before this tick's updates, the lowest-index free slot loads row=fire_row, col=fire_col and becomes live.
  - a slot retired in the same tick is not reusable until the next attempt.
  - no free slot, or fire_valid=0: attempt dropped; counter still resets.
  - a newly loaded bomb does not move or hit-check on its launch tick.
- Rendering (combinational from registered slot state):
  - bomb_active = OR over live slots of (r < pixel_row < r+5) && (c+14 < pixel_column < c+17).
  - zero latency relative to pixel_row/pixel_column.
- Width rule: BOTTOM_ROW + STEP must be < 4096, so row arithmetic never wraps for legal fire_row.

Test Plan:
Bench uses MOVE_DIV=4, FIRE_INTERVAL=2.
- Reset, then game_en=1, fire_valid=1, fire_col=100, fire_row=50, player_column=305 -> after 2 ticks bombs_live=4'b0001. Probe pixel (51,115): bomb_active=1, bomb_output=4'hF. Probe (51,117): bomb_active=0.
- Let slot 0 fall with no player overlap -> row advances 2 per tick (cycle-accurate at 4-clk spacing), retires when row reaches 470. bombs_live[0] clears on that tick; player_hit stays 0.
- fire_col=305, player_column=305, fire_row=420 -> on the tick the row becomes 436 (bottom pixel 440 < 441) there is no hit. On the next tick, at row 438 (bottom pixel 442), the slot is freed and player_hit pulses for exactly 1 cycle.
- fire_valid held 1 with bombs unable to retire (fire_row=0, BOTTOM_ROW unreachable within the window) -> slots fill in order 0,1,2,3. The 5th attempt is dropped: bombs_live stays 4'b1111 and no slot is overwritten.
- Two bombs overlap the player on the same tick -> both slots freed, single 1-cycle player_hit pulse.
- rst asserted mid-flight with 3 live bombs, and separately game_en=0 for 20 cycles:
  - rst case: all outputs 0 the next cycle.
  - game_en=0 case: row/col and bombs_live unchanged and no ticks occur; motion resumes exactly where it stopped when game_en returns to 1.

Source files
------------

// File: rtl/alien_bomb.sv
// Alien bomb pool: launches shots from the selected invader column, drops them on a
// divided motion tick, reports player strikes and renders a 2x4 pixel mask per live bomb.
module alien_bomb #(
    parameter int NUM_BOMBS     = 4,
    parameter int MOVE_DIV      = 250000,
    parameter int STEP          = 2,
    parameter int FIRE_INTERVAL = 32,
    parameter int BOTTOM_ROW    = 470,
    parameter int PLAYER_ROW    = 440
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [11:0]          pixel_row,
    input  logic [11:0]          pixel_column,
    input  logic [11:0]          fire_col,
    input  logic [11:0]          fire_row,
    input  logic                 fire_valid,
    input  logic [11:0]          player_column,
    input  logic                 game_en,
    output logic                 bomb_active,
    output logic [3:0]           bomb_output,
    output logic                 player_hit,
    output logic [NUM_BOMBS-1:0] bombs_live
);

    localparam int MW = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
    localparam int FW = (FIRE_INTERVAL > 1) ? $clog2(FIRE_INTERVAL) : 1;
    localparam logic [12:0] PR_TOP = 13'(PLAYER_ROW + 1);
    localparam logic [12:0] PR_BOT = 13'(PLAYER_ROW + 20);

    logic [MW-1:0]        move_cnt_reg;
    logic [FW-1:0]        fire_cnt_reg;
    logic [NUM_BOMBS-1:0] live_reg, live_next;
    logic [11:0]          row_reg [NUM_BOMBS];
    logic [11:0]          col_reg [NUM_BOMBS];
    logic [11:0]          row_next [NUM_BOMBS];
    logic [11:0]          col_next [NUM_BOMBS];
    logic                 hit_reg, hit_next;

    logic                 tick;
    logic                 fire_now;
    logic [11:0]          row_step [NUM_BOMBS];
    logic [NUM_BOMBS-1:0] slot_hit;
    logic [NUM_BOMBS-1:0] slot_done;
    logic [NUM_BOMBS-1:0] pix_hit;
    logic [12:0]          prow13, pcol13, pc13;

    assign tick     = game_en && (move_cnt_reg == MW'(MOVE_DIV - 1));
    assign fire_now = tick && (fire_cnt_reg == FW'(FIRE_INTERVAL - 1));
    assign prow13   = {1'b0, pixel_row};
    assign pcol13   = {1'b0, pixel_column};
    assign pc13     = {1'b0, player_column};

    // Per-slot geometry; 13-bit compares so the +offsets can never wrap.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_BOMBS; gi++) begin : g_slot
            logic [12:0] r13, c13, rn13;
            assign row_step[gi] = row_reg[gi] + 12'(STEP);
            assign r13  = {1'b0, row_reg[gi]};
            assign c13  = {1'b0, col_reg[gi]};
            assign rn13 = {1'b0, row_step[gi]};
            assign slot_hit[gi] = live_reg[gi]
                && (rn13 + 13'd1 <= PR_BOT) && (rn13 + 13'd4 >= PR_TOP)
                && (c13 + 13'd15 <= pc13 + 13'd30) && (c13 + 13'd16 >= pc13 + 13'd1);
            assign slot_done[gi] = (row_step[gi] >= 12'(BOTTOM_ROW));
            assign pix_hit[gi] = live_reg[gi]
                && (prow13 > r13) && (prow13 < r13 + 13'd5)
                && (pcol13 > c13 + 13'd14) && (pcol13 < c13 + 13'd17);
        end
    endgenerate

    always_comb begin
        logic found;
        live_next = live_reg;
        row_next  = row_reg;
        col_next  = col_reg;
        hit_next  = 1'b0;
        found     = 1'b0;
        if (tick) begin
            for (int i = 0; i < NUM_BOMBS; i++) begin
                if (live_reg[i]) begin
                    if (slot_hit[i]) begin
                        live_next[i] = 1'b0;
                        hit_next     = 1'b1;
                    end else if (slot_done[i]) begin
                        live_next[i] = 1'b0;
                    end else begin
                        row_next[i] = row_step[i];
                    end
                end
            end
        end
        // Only slots free before this tick qualify, so a retiring slot is never reused at once.
        if (fire_now && fire_valid) begin
            for (int i = 0; i < NUM_BOMBS; i++) begin
                if (!live_reg[i] && !found) begin
                    found        = 1'b1;
                    live_next[i] = 1'b1;
                    row_next[i]  = fire_row;
                    col_next[i]  = fire_col;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            move_cnt_reg <= '0;
            fire_cnt_reg <= '0;
            live_reg     <= '0;
            hit_reg      <= 1'b0;
            for (int i = 0; i < NUM_BOMBS; i++) begin
                row_reg[i] <= '0;
                col_reg[i] <= '0;
            end
        end else begin
            hit_reg  <= hit_next;
            live_reg <= live_next;
            row_reg  <= row_next;
            col_reg  <= col_next;
            if (game_en) begin
                move_cnt_reg <= tick ? '0 : move_cnt_reg + MW'(1);
            end
            if (tick) begin
                fire_cnt_reg <= (fire_cnt_reg == FW'(FIRE_INTERVAL - 1)) ? '0 : fire_cnt_reg + FW'(1);
            end
        end
    end

    assign bomb_active = |pix_hit;
    assign bomb_output = {4{bomb_active}};
    assign player_hit  = hit_reg;
    assign bombs_live  = live_reg;

endmodule

// File: tb/tb_alien_bomb.sv
// Bench for alien_bomb with a short motion divider; expected slot occupancy and hit
// pulses are queued per tick and compared when the tick completes.
module tb_alien_bomb;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] pixel_row = '0;
    logic [11:0] pixel_column = '0;
    logic [11:0] fire_col = '0;
    logic [11:0] fire_row = '0;
    logic        fire_valid = 1'b0;
    logic [11:0] player_column = 12'd305;
    logic        game_en = 1'b0;
    logic        bomb_active;
    logic [3:0]  bomb_output;
    logic        player_hit;
    logic [3:0]  bombs_live;

    typedef struct {
        logic [3:0] live;
        logic       hit;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    alien_bomb #(
        .NUM_BOMBS(4), .MOVE_DIV(4), .STEP(2), .FIRE_INTERVAL(2),
        .BOTTOM_ROW(470), .PLAYER_ROW(440)
    ) dut (
        .clk(clk), .rst(rst), .pixel_row(pixel_row), .pixel_column(pixel_column),
        .fire_col(fire_col), .fire_row(fire_row), .fire_valid(fire_valid),
        .player_column(player_column), .game_en(game_en),
        .bomb_active(bomb_active), .bomb_output(bomb_output),
        .player_hit(player_hit), .bombs_live(bombs_live)
    );

    task automatic do_reset();
        rst     = 1'b1;
        game_en = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_tick();
        repeat (4) @(negedge clk);
    endtask

    task automatic probe(input int r, input int c, output logic a, output logic [3:0] o);
        pixel_row    = 12'(r);
        pixel_column = 12'(c);
        #1;
        a = bomb_active;
        o = bomb_output;
    endtask

    task automatic test_reset();
        logic a; logic [3:0] o;
        do_reset();
        probe(1, 15, a, o);
        checks++;
        if (bombs_live !== 4'b0000 || player_hit !== 1'b0 || a !== 1'b0 || o !== 4'h0) begin
            errors++;
            $display("FAIL reset: live=%b hit=%b active=%b out=%h required 0000 0 0 0",
                     bombs_live, player_hit, a, o);
        end
    endtask

    task automatic test_fire_render();
        logic a; logic [3:0] o;
        fire_col = 12'd100; fire_row = 12'd50; player_column = 12'd305; fire_valid = 1'b1;
        exp_q.push_back('{4'b0000, 1'b0});
        exp_q.push_back('{4'b0001, 1'b0});
        for (int t = 1; t <= 2; t++) begin
            wait_tick();
            e = exp_q.pop_front();
            checks++;
            if (bombs_live !== e.live || player_hit !== e.hit) begin
                errors++;
                $display("FAIL fire tick %0d: live=%b hit=%b required %b %b", t, bombs_live, player_hit, e.live, e.hit);
            end
        end
        fire_valid = 1'b0;
        probe(51, 115, a, o);
        checks++;
        if (a !== 1'b1 || o !== 4'hF) begin
            errors++;
            $display("FAIL render inside: active=%b out=%h required 1 F", a, o);
        end
        probe(51, 117, a, o);
        checks++;
        if (a !== 1'b0 || o !== 4'h0) begin
            errors++;
            $display("FAIL render right edge: active=%b out=%h required 0 0", a, o);
        end
    endtask

    task automatic test_fall();
        logic a_in, a_out; logic [3:0] o;
        for (int k = 1; k <= 210; k++) begin
            int r_exp;
            r_exp = 50 + 2 * k;
            exp_q.push_back('{(r_exp >= 470) ? 4'b0000 : 4'b0001, 1'b0});
            wait_tick();
            e = exp_q.pop_front();
            checks++;
            if (bombs_live !== e.live || player_hit !== e.hit) begin
                errors++;
                $display("FAIL fall tick %0d: live=%b hit=%b required %b %b", k, bombs_live, player_hit, e.live, e.hit);
            end
            if (r_exp < 470) begin
                probe(r_exp + 1, 115, a_in, o);
                probe(r_exp, 115, a_out, o);
                checks++;
                if (a_in !== 1'b1 || a_out !== 1'b0) begin
                    errors++;
                    $display("FAIL fall row %0d: top=%b above=%b required 1 0", r_exp, a_in, a_out);
                end
            end
        end
        probe(471, 115, a_in, o);
        checks++;
        if (a_in !== 1'b0) begin
            errors++;
            $display("FAIL retired render: active=%b required 0", a_in);
        end
    endtask

    task automatic test_hit();
        logic a; logic [3:0] o;
        do_reset();
        fire_col = 12'd305; player_column = 12'd305; fire_row = 12'd420; fire_valid = 1'b1;
        exp_q.push_back('{4'b0000, 1'b0});
        exp_q.push_back('{4'b0001, 1'b0});
        for (int k = 1; k <= 8; k++) exp_q.push_back('{4'b0001, 1'b0});
        exp_q.push_back('{4'b0000, 1'b1});
        for (int t = 1; t <= 11; t++) begin
            wait_tick();
            if (t == 2) fire_valid = 1'b0;
            e = exp_q.pop_front();
            checks++;
            if (bombs_live !== e.live || player_hit !== e.hit) begin
                errors++;
                $display("FAIL hit tick %0d: live=%b hit=%b required %b %b", t, bombs_live, player_hit, e.live, e.hit);
            end
            if (t == 10) begin
                probe(437, 320, a, o);
                checks++;
                if (a !== 1'b1) begin
                    errors++;
                    $display("FAIL hit row 436 render: active=%b required 1", a);
                end
            end
        end
        @(negedge clk);
        checks++;
        if (player_hit !== 1'b0) begin
            errors++;
            $display("FAIL hit pulse width: hit=%b required 0", player_hit);
        end
    endtask

    task automatic test_fill();
        logic a; logic [3:0] o;
        logic [3:0] seq [10];
        seq = '{4'h0, 4'h1, 4'h1, 4'h3, 4'h3, 4'h7, 4'h7, 4'hF, 4'hF, 4'hF};
        do_reset();
        fire_row = 12'd0; fire_col = 12'd0; player_column = 12'd305; fire_valid = 1'b1;
        for (int t = 0; t < 10; t++) exp_q.push_back('{seq[t], 1'b0});
        for (int t = 1; t <= 10; t++) begin
            wait_tick();
            e = exp_q.pop_front();
            checks++;
            if (bombs_live !== e.live || player_hit !== e.hit) begin
                errors++;
                $display("FAIL fill tick %0d: live=%b hit=%b required %b %b", t, bombs_live, player_hit, e.live, e.hit);
            end
        end
        fire_valid = 1'b0;
        for (int p = 0; p < 4; p++) begin
            int pr; logic ex;
            pr = (p == 0) ? 17 : (p == 1) ? 5 : (p == 2) ? 1 : 21;
            ex = (p < 2);
            probe(pr, 15, a, o);
            checks++;
            if (a !== ex) begin
                errors++;
                $display("FAIL fill render row %0d: active=%b required %b", pr, a, ex);
            end
        end
    endtask

    task automatic test_double_hit();
        int pulses;
        do_reset();
        fire_col = 12'd305; player_column = 12'd305; fire_row = 12'd420; fire_valid = 1'b1;
        exp_q.push_back('{4'b0000, 1'b0});
        exp_q.push_back('{4'b0001, 1'b0});
        exp_q.push_back('{4'b0001, 1'b0});
        for (int k = 4; k <= 10; k++) exp_q.push_back('{4'b0011, 1'b0});
        exp_q.push_back('{4'b0000, 1'b1});
        for (int t = 1; t <= 11; t++) begin
            wait_tick();
            if (t == 2) fire_row = 12'd424;
            if (t == 4) fire_valid = 1'b0;
            e = exp_q.pop_front();
            checks++;
            if (bombs_live !== e.live || player_hit !== e.hit) begin
                errors++;
                $display("FAIL double tick %0d: live=%b hit=%b required %b %b", t, bombs_live, player_hit, e.live, e.hit);
            end
        end
        pulses = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (player_hit === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL double pulse count: extra=%0d required 0", pulses);
        end
    endtask

    task automatic test_reset_midflight();
        logic a; logic [3:0] o;
        do_reset();
        fire_row = 12'd0; fire_col = 12'd0; fire_valid = 1'b1;
        for (int t = 0; t < 6; t++) exp_q.push_back('{(t < 1) ? 4'h0 : (t < 3) ? 4'h1 : (t < 5) ? 4'h3 : 4'h7, 1'b0});
        for (int t = 1; t <= 6; t++) begin
            wait_tick();
            e = exp_q.pop_front();
            checks++;
            if (bombs_live !== e.live || player_hit !== e.hit) begin
                errors++;
                $display("FAIL midflight tick %0d: live=%b hit=%b required %b %b", t, bombs_live, player_hit, e.live, e.hit);
            end
        end
        rst = 1'b1;
        @(negedge clk);
        probe(9, 15, a, o);
        checks++;
        if (bombs_live !== 4'b0000 || player_hit !== 1'b0 || a !== 1'b0 || o !== 4'h0) begin
            errors++;
            $display("FAIL midflight reset: live=%b hit=%b active=%b out=%h required 0000 0 0 0",
                     bombs_live, player_hit, a, o);
        end
        rst = 1'b0;
        fire_valid = 1'b0;
    endtask

    task automatic test_freeze();
        logic a3, a5; logic [3:0] o;
        int bad;
        do_reset();
        fire_row = 12'd0; fire_col = 12'd0; fire_valid = 1'b1;
        exp_q.push_back('{4'b0000, 1'b0});
        exp_q.push_back('{4'b0001, 1'b0});
        exp_q.push_back('{4'b0001, 1'b0});
        for (int t = 1; t <= 3; t++) begin
            wait_tick();
            if (t == 2) fire_valid = 1'b0;
            e = exp_q.pop_front();
            checks++;
            if (bombs_live !== e.live || player_hit !== e.hit) begin
                errors++;
                $display("FAIL freeze tick %0d: live=%b hit=%b required %b %b", t, bombs_live, player_hit, e.live, e.hit);
            end
        end
        @(negedge clk);
        game_en = 1'b0;
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bombs_live !== 4'b0001 || player_hit !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL freeze hold: bad_cycles=%0d required 0", bad);
        end
        probe(3, 15, a3, o);
        checks++;
        if (a3 !== 1'b1) begin
            errors++;
            $display("FAIL freeze row: active_at_3=%b required 1", a3);
        end
        game_en = 1'b1;
        repeat (2) @(negedge clk);
        probe(3, 15, a3, o);
        checks++;
        if (a3 !== 1'b1) begin
            errors++;
            $display("FAIL resume early move: active_at_3=%b required 1", a3);
        end
        @(negedge clk);
        probe(3, 15, a3, o);
        probe(5, 15, a5, o);
        checks++;
        if (a3 !== 1'b0 || a5 !== 1'b1) begin
            errors++;
            $display("FAIL resume move: row3=%b row5=%b required 0 1", a3, a5);
        end
    endtask

    initial begin
        test_reset();
        test_fire_render();
        test_fall();
        test_hit();
        test_fill();
        test_double_hit();
        test_reset_midflight();
        test_freeze();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
